// File: rtl/pc_gen_ras_if.sv
// Fetch-PC generator bus: trap, decode-return and execute-resolution inputs,
// and the registered fetch PC and status outputs.
interface pc_gen_ras_if #(
    parameter int unsigned XLEN = 32
);
    logic            stall;
    logic            trap_valid;
    logic [XLEN-1:0] trap_target;
    logic            dec_valid;
    logic            dec_is_ret;
    logic            ex_valid;
    logic            ex_jal;
    logic            ex_jalr;
    logic            ex_branch_taken;
    logic            ex_is_call;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_pred_next;
    logic [XLEN-1:0] pc;
    logic            redirect;
    logic            misalign_err;
    logic            ras_empty;

    modport master (
        output stall, trap_valid, trap_target, dec_valid, dec_is_ret,
               ex_valid, ex_jal, ex_jalr, ex_branch_taken, ex_is_call,
               ex_pc, ex_imm, ex_rs1_data, ex_pred_next,
        input  pc, redirect, misalign_err, ras_empty
    );

    modport slave (
        input  stall, trap_valid, trap_target, dec_valid, dec_is_ret,
               ex_valid, ex_jal, ex_jalr, ex_branch_taken, ex_is_call,
               ex_pc, ex_imm, ex_rs1_data, ex_pred_next,
        output pc, redirect, misalign_err, ras_empty
    );
endinterface

// File: rtl/pc_gen_ras.sv
// RV32 fetch next-PC generator: execute-resolved redirects, traps, stalls and
// return prediction through a circular return address stack.
module pc_gen_ras #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     RAS_DEPTH    = 4,
    parameter int unsigned     RAS_PTR_W    = $clog2(RAS_DEPTH)
) (
    input logic          clk,
    input logic          reset,
    pc_gen_ras_if.slave  bus
);
    localparam int unsigned CNT_W = RAS_PTR_W + 1;

    logic [XLEN-1:0]      ras_mem [RAS_DEPTH];
    logic [RAS_PTR_W-1:0] top_ptr;
    logic [CNT_W-1:0]     ras_cnt;

    logic [XLEN-1:0]      jalr_sum_c;
    logic [XLEN-1:0]      resolved_c;
    logic                 mispredict_c;
    logic                 misalign_c;
    logic                 redirect_ex_c;
    logic                 push_c;
    logic                 pop_c;
    logic [RAS_PTR_W-1:0] ptr_nxt_c;
    logic [CNT_W-1:0]     cnt_nxt_c;
    logic [RAS_PTR_W-1:0] wr_idx_c;
    logic [XLEN-1:0]      pc_nxt_c;
    logic                 redirect_nxt_c;

    // Resolve the execute target and classify the outcome.
    always_comb begin
        jalr_sum_c = bus.ex_rs1_data + bus.ex_imm;
        if (bus.ex_jalr)
            resolved_c = {jalr_sum_c[XLEN-1:1], 1'b0};
        else if (bus.ex_jal || bus.ex_branch_taken)
            resolved_c = bus.ex_pc + bus.ex_imm;
        else
            resolved_c = bus.ex_pc + XLEN'(4);
        mispredict_c  = bus.ex_valid && (resolved_c != bus.ex_pred_next);
        misalign_c    = mispredict_c && resolved_c[1];
        redirect_ex_c = mispredict_c && !resolved_c[1];
        push_c = bus.ex_valid && (bus.ex_jal || bus.ex_jalr) && bus.ex_is_call &&
                 !bus.trap_valid && !misalign_c;
        pop_c  = !bus.trap_valid && !redirect_ex_c && !bus.stall &&
                 bus.dec_valid && bus.dec_is_ret && (ras_cnt != '0);
    end

    // Stack pointer/count update; a same-cycle push and pop rewrite the top slot.
    always_comb begin
        ptr_nxt_c = top_ptr;
        cnt_nxt_c = ras_cnt;
        wr_idx_c  = top_ptr + RAS_PTR_W'(1);
        if (bus.trap_valid) begin
            cnt_nxt_c = '0;
        end else if (push_c && pop_c) begin
            wr_idx_c = top_ptr;
        end else if (push_c) begin
            ptr_nxt_c = top_ptr + RAS_PTR_W'(1);
            if (ras_cnt != CNT_W'(RAS_DEPTH))
                cnt_nxt_c = ras_cnt + CNT_W'(1);
        end else if (pop_c) begin
            ptr_nxt_c = top_ptr - RAS_PTR_W'(1);
            cnt_nxt_c = ras_cnt - CNT_W'(1);
        end
    end

    always_comb begin
        pc_nxt_c       = bus.pc + XLEN'(4);
        redirect_nxt_c = 1'b0;
        if (bus.trap_valid) begin
            pc_nxt_c       = bus.trap_target;
            redirect_nxt_c = 1'b1;
        end else if (redirect_ex_c) begin
            pc_nxt_c       = resolved_c;
            redirect_nxt_c = 1'b1;
        end else if (bus.stall) begin
            pc_nxt_c = bus.pc;
        end else if (pop_c) begin
            pc_nxt_c = ras_mem[top_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.pc           <= RESET_VECTOR;
            bus.redirect     <= 1'b0;
            bus.misalign_err <= 1'b0;
            bus.ras_empty    <= 1'b1;
            top_ptr          <= '0;
            ras_cnt          <= '0;
        end else begin
            bus.pc           <= pc_nxt_c;
            bus.redirect     <= redirect_nxt_c;
            bus.misalign_err <= misalign_c;
            bus.ras_empty    <= (cnt_nxt_c == '0);
            top_ptr          <= ptr_nxt_c;
            ras_cnt          <= cnt_nxt_c;
        end
    end

    // Entries are only meaningful below the count, so the array needs no reset.
    always_ff @(posedge clk) begin
        if (!reset && push_c)
            ras_mem[wr_idx_c] <= bus.ex_pc + XLEN'(4);
    end
endmodule

// File: tb/tb_pc_gen_ras.sv
// Directed bench for pc_gen_ras: ordered vector table plus hand sequences.
module tb_pc_gen_ras;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    pc_gen_ras_if #(.XLEN(32)) bus ();

    pc_gen_ras #(
        .XLEN(32),
        .RESET_VECTOR(32'h0000_0100),
        .RAS_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        trap;
        logic [31:0] trap_tgt;
        logic        ret;
        logic        exv;
        logic        jal;
        logic        jalr;
        logic        taken;
        logic        call;
        logic [31:0] epc;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] pred;
        logic [31:0] exp_pc;
        logic        exp_red;
        logic        exp_mis;
        logic        exp_empty;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(logic [31:0] p, logic r, logic m, logic e);
        vec_t t;
        t.rst = 0; t.stall = 0; t.trap = 0; t.trap_tgt = '0; t.ret = 0;
        t.exv = 0; t.jal = 0; t.jalr = 0; t.taken = 0; t.call = 0;
        t.epc = '0; t.imm = '0; t.rs1 = '0; t.pred = '0;
        t.exp_pc = p; t.exp_red = r; t.exp_mis = m; t.exp_empty = e;
        return t;
    endfunction

    function automatic vec_t cf(vec_t b, logic jal, logic jalr, logic tk, logic call,
                                logic [31:0] epc, logic [31:0] imm,
                                logic [31:0] rs1, logic [31:0] pred);
        vec_t t = b;
        t.exv = 1; t.jal = jal; t.jalr = jalr; t.taken = tk; t.call = call;
        t.epc = epc; t.imm = imm; t.rs1 = rs1; t.pred = pred;
        return t;
    endfunction

    function automatic vec_t with_ret(vec_t b);
        vec_t t = b;
        t.ret = 1;
        return t;
    endfunction

    task automatic drive(vec_t t);
        reset               = t.rst;
        bus.stall           = t.stall;
        bus.trap_valid      = t.trap;
        bus.trap_target     = t.trap_tgt;
        bus.dec_valid       = t.ret;
        bus.dec_is_ret      = t.ret;
        bus.ex_valid        = t.exv;
        bus.ex_jal          = t.jal;
        bus.ex_jalr         = t.jalr;
        bus.ex_branch_taken = t.taken;
        bus.ex_is_call      = t.call;
        bus.ex_pc           = t.epc;
        bus.ex_imm          = t.imm;
        bus.ex_rs1_data     = t.rs1;
        bus.ex_pred_next    = t.pred;
    endtask

    task automatic chk(string nm, int idx, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, got, exp);
        end
    endtask

    // Apply one vector across a rising edge and compare the registered outputs.
    task automatic run(vec_t t, int idx);
        drive(t);
        @(posedge clk);
        #1;
        chk("pc",           idx, bus.pc,                  t.exp_pc);
        chk("redirect",     idx, 32'(bus.redirect),       32'(t.exp_red));
        chk("misalign_err", idx, 32'(bus.misalign_err),   32'(t.exp_mis));
        chk("ras_empty",    idx, 32'(bus.ras_empty),      32'(t.exp_empty));
    endtask

    initial begin
        vec_t t;
        drive(mk('0, 0, 0, 1));
        reset = 1'b1;

        // Reset and free-running fetch
        t = mk(32'h100, 0, 0, 1); t.rst = 1; vecs.push_back(t); vecs.push_back(t);
        vecs.push_back(mk(32'h104, 0, 0, 1));
        vecs.push_back(mk(32'h108, 0, 0, 1));
        // JALR mispredict with low bit cleared
        vecs.push_back(cf(mk(32'h2010, 1, 0, 1), 0, 1, 0, 0, 32'h0, 32'h10, 32'h2001, 32'h44));
        vecs.push_back(mk(32'h2014, 0, 0, 1));
        // Call then predicted return
        vecs.push_back(cf(mk(32'h2018, 0, 0, 0), 1, 0, 0, 1, 32'h200, 32'h40, 32'h0, 32'h240));
        vecs.push_back(with_ret(mk(32'h204, 0, 0, 1)));
        vecs.push_back(mk(32'h208, 0, 0, 1));
        // Return predicted while empty falls through
        vecs.push_back(with_ret(mk(32'h20C, 0, 0, 1)));
        // Overflow: five calls into a four-deep stack, then five returns
        for (int i = 0; i < 5; i++) begin
            logic [31:0] epc;
            epc = 32'(32'h10 * (i + 1));
            vecs.push_back(cf(mk(32'h210 + 32'(4 * i), 0, 0, 0), 1, 0, 0, 1,
                              epc, 32'h1000, 32'h0, epc + 32'h1000));
        end
        vecs.push_back(with_ret(mk(32'h54, 0, 0, 0)));
        vecs.push_back(with_ret(mk(32'h44, 0, 0, 0)));
        vecs.push_back(with_ret(mk(32'h34, 0, 0, 0)));
        vecs.push_back(with_ret(mk(32'h24, 0, 0, 1)));
        vecs.push_back(with_ret(mk(32'h28, 0, 0, 1)));
        // Stall against redirect and against pop
        vecs.push_back(cf(mk(32'h2C, 0, 0, 0), 1, 0, 0, 1, 32'h300, 32'h8, 32'h0, 32'h308));
        t = cf(mk(32'h800, 1, 0, 0), 0, 0, 1, 0, 32'h700, 32'h100, 32'h0, 32'h704);
        t.stall = 1; vecs.push_back(t);
        t = with_ret(mk(32'h800, 0, 0, 0)); t.stall = 1; vecs.push_back(t);
        vecs.push_back(with_ret(mk(32'h304, 0, 0, 1)));
        // Same-cycle push and pop
        vecs.push_back(cf(mk(32'h308, 0, 0, 0), 1, 0, 0, 1, 32'h400, 32'h4, 32'h0, 32'h404));
        vecs.push_back(with_ret(cf(mk(32'h404, 0, 0, 0), 1, 0, 0, 1, 32'h500, 32'h4, 32'h0, 32'h504)));
        vecs.push_back(with_ret(mk(32'h504, 0, 0, 1)));
        // Trap beats mispredict and clears the stack
        vecs.push_back(cf(mk(32'h508, 0, 0, 0), 1, 0, 0, 1, 32'h600, 32'h4, 32'h0, 32'h604));
        t = cf(mk(32'h1C0, 1, 0, 1), 0, 0, 1, 0, 32'h800, 32'h100, 32'h0, 32'h804);
        t.trap = 1; t.trap_tgt = 32'h1C0; vecs.push_back(t);
        // Misaligned targets: no redirect, no push
        vecs.push_back(cf(mk(32'h1C4, 0, 1, 1), 0, 0, 1, 0, 32'h900, 32'h2, 32'h0, 32'h904));
        vecs.push_back(cf(mk(32'h1C8, 0, 1, 1), 1, 0, 0, 1, 32'hA00, 32'h6, 32'h0, 32'hA04));
        vecs.push_back(mk(32'h1CC, 0, 0, 1));
        // Trap under stall, then plain stall
        t = mk(32'h3000, 1, 0, 1); t.stall = 1; t.trap = 1; t.trap_tgt = 32'h3000; vecs.push_back(t);
        t = mk(32'h3000, 0, 0, 1); t.stall = 1; vecs.push_back(t);
        // JALR add wraps modulo 2^32; correct prediction causes no redirect
        vecs.push_back(cf(mk(32'h10, 1, 0, 1), 0, 1, 0, 0, 32'h0, 32'h20, 32'hFFFF_FFF0, 32'h0));
        vecs.push_back(cf(mk(32'h14, 0, 0, 1), 0, 1, 0, 0, 32'h0, 32'h4, 32'h20, 32'h24));
        // Aligned mispredict blocks a pop
        vecs.push_back(cf(mk(32'h18, 0, 0, 0), 1, 0, 0, 1, 32'h40, 32'h4, 32'h0, 32'h44));
        vecs.push_back(with_ret(cf(mk(32'h84, 1, 0, 0), 0, 0, 0, 0, 32'h80, 32'h0, 32'h0, 32'h90)));
        vecs.push_back(with_ret(mk(32'h44, 0, 0, 1)));

        foreach (vecs[i]) run(vecs[i], i);

        // Reset mid-operation discards a pending trap and the stacked return
        run(cf(mk(32'h48, 0, 0, 0), 1, 0, 0, 1, 32'h700, 32'h4, 32'h0, 32'h704), 1000);
        t = with_ret(mk(32'h100, 0, 0, 1)); t.rst = 1; t.trap = 1; t.trap_tgt = 32'h5000;
        run(t, 1001);
        run(with_ret(mk(32'h104, 0, 0, 1)), 1002);

        // Redirect is a single-cycle pulse
        run(cf(mk(32'hC00, 1, 0, 1), 0, 0, 1, 0, 32'hB00, 32'h100, 32'h0, 32'hB04), 1003);
        run(mk(32'hC04, 0, 0, 1), 1004);
        run(mk(32'hC08, 0, 0, 1), 1005);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_gen_ras.md
Name: pc_gen_ras

Overview:
- Sequential next-PC generator for the RV32 fetch front end.
- Holds the architectural fetch PC register and resolves control flow from execute.
- Detects mispredictions and redirects fetch to the correct target.
- Predicts function returns at decode using a parametrised return address stack (RAS); handles trap redirects and fetch stalls.

Parameters:
- XLEN, 32, datapath/address width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- RAS_DEPTH, 4, number of RAS entries (power of 2, >=2).
- RAS_PTR_W, $clog2(RAS_DEPTH), RAS pointer width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold fetch PC (pipeline back-pressure)
- trap_valid  in  1  trap/exception taken this cycle
- trap_target  in  XLEN  trap handler address
- dec_valid  in  1  valid instruction in decode
- dec_is_ret  in  1  decode instr is a return (jalr x0, 0(x1/x5))
- ex_valid  in  1  valid control-flow instr resolving in execute
- ex_jal  in  1  execute instr is JAL
- ex_jalr  in  1  execute instr is JALR
- ex_branch_taken  in  1  conditional branch resolved taken
- ex_is_call  in  1  instr writes link reg x1/x5 (JAL/JALR)
- ex_pc  in  XLEN  PC of execute instr
- ex_imm  in  XLEN  sign-extended immediate
- ex_rs1_data  in  XLEN  rs1 operand
- ex_pred_next  in  XLEN  PC that fetch actually followed after ex_pc
- pc  out  XLEN  current fetch PC
- redirect  out  1  one-cycle pulse: fetch redirected (trap or mispredict)
- misalign_err  out  1  one-cycle pulse: resolved target not 4-byte aligned
- ras_empty  out  1  RAS holds no valid entries

Behaviour:
- Reset (sync, active-high; dominates all inputs):
  - pc=RESET_VECTOR; RAS count=0, top pointer=0.
  - redirect=0, misalign_err=0, ras_empty=1.
- Resolved target, computed combinationally when ex_valid:
  - jalr: (ex_rs1_data+ex_imm) & ~1.
  - jal or ex_branch_taken: ex_pc+ex_imm.
  - else: ex_pc+4.
  - All adds are modulo 2^XLEN (wrap, no carry-out).
- Mispredict: ex_valid && resolved != ex_pred_next.
- Misalignment: resolved[1]=1 on a mispredict -> misalign_err pulses next cycle; pc not changed by ex; no redirect; no RAS push.
- Next-PC priority, registered; latency 1 cycle:
  1. trap_valid -> pc<=trap_target, redirect<=1, RAS cleared (count=0).
  2. Aligned mispredict -> pc<=resolved, redirect<=1.
  3. stall -> pc holds, redirect<=0.
  4. dec_valid && dec_is_ret && !ras_empty -> pc<=RAS top, pop.
  5. else pc<=pc+4.
- Redirect override: trap and mispredict redirects take effect even while stall=1.
- RAS push: ex_valid && (ex_jal||ex_jalr) && ex_is_call && no trap && no misalign_err condition.
  - Pushes ex_pc+4, independent of stall.
- RAS pop: only on priority case 4; blocked by stall, trap or mispredict.
- Simultaneous push and pop (same cycle):
  - Pop predicts the old top.
  - The pushed value replaces the top slot; count unchanged.
- Overflow: push when count==RAS_DEPTH -> pointer wraps, oldest entry overwritten, count saturates at RAS_DEPTH.
- Underflow: a return predicted while empty performs no pop; pc<=pc+4, and execute corrects it through the mispredict path.
- ras_empty = (count==0), registered with the state.
- Reset mid-operation discards pending redirects and the RAS contents.

Test Plan:
- Reset sequence: reset=1 for 2 cycles with RESET_VECTOR=32'h100 -> pc=0x100, redirect=0, ras_empty=1; after release and with no events, pc steps 0x104, 0x108.
- JALR mispredict: ex_valid, ex_jalr, rs1=0x2001, imm=0x10, ex_pred_next=0x44 -> next cycle pc=0x2010, redirect=1 for one cycle.
- Call/return prediction: JAL call at ex_pc=0x200 with ex_is_call=1, then dec_is_ret=1 -> pc=0x204 with no redirect; ras_empty returns to 1.
- Overflow: RAS_DEPTH=4, push 5 calls (0x10..0x50), then pop 5 times -> predictions 0x54, 0x44, 0x34, 0x24, then one pc+4 fall-through because RAS is empty after 4 pops.
- Stall vs redirect: stall=1 with a branch mispredict to 0x800 -> pc=0x800; stall=1 with dec_is_ret -> pc holds and RAS count unchanged.
- Trap over mispredict: trap_target=0x1C0 together with a mispredict to 0x900 -> pc=0x1C0, redirect=1, ras_empty=1; a branch target 0x902 sets misalign_err=1 and pc is not redirected.
